// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
// Shared AES definitions for the iterative encryption datapath:
//   aes_block_t      128-bit block, byte 0 in [127:120], column-major state
//   NR_AES128        round count for AES-128
//   aes_enc_state_e  controller states IDLE/RUN/DONE
//   SBOX / sbox()    forward S-box lookup
//   xtime()          multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1
// ---------------------------------------------------------------------------
package aes_pkg;

  typedef logic [127:0] aes_block_t;

  localparam int NR_AES128 = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } aes_enc_state_e;

  // Entry 0 is the leftmost literal because the outer range ascends.
  localparam logic [0:255][7:0] SBOX = {
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_round.sv
// ---------------------------------------------------------------------------
// aes_round
// One combinational AES encryption round.
//   state_in    in  128  current state
//   round_key   in  128  key for this round
//   final_round in  1    1 = skip MixColumns (last round)
//   state_out   out 128  SubBytes, ShiftRows, [MixColumns], AddRoundKey
// Byte i of the block sits at [127-8i -: 8]; byte i is row i%4, column i/4.
// ---------------------------------------------------------------------------
module aes_round
  import aes_pkg::*;
(
  input  aes_block_t state_in,
  input  aes_block_t round_key,
  input  logic       final_round,
  output aes_block_t state_out
);

  logic [7:0] sb [16];
  logic [7:0] sr [16];
  logic [7:0] mc [16];

  genvar gi;

  for (gi = 0; gi < 16; gi++) begin : g_bytes
    localparam int ROW = gi % 4;
    localparam int COL = gi / 4;
    assign sb[gi] = sbox(state_in[127-8*gi -: 8]);
    // Row r rotates left by r columns.
    assign sr[gi] = sb[4*((COL + ROW) % 4) + ROW];
    assign state_out[127-8*gi -: 8] =
      (final_round ? sr[gi] : mc[gi]) ^ round_key[127-8*gi -: 8];
  end

  for (gi = 0; gi < 4; gi++) begin : g_mix
    logic [7:0] a0, a1, a2, a3;
    assign a0 = sr[4*gi];
    assign a1 = sr[4*gi+1];
    assign a2 = sr[4*gi+2];
    assign a3 = sr[4*gi+3];
    // Circulant matrix {02,03,01,01}; 03*x expressed as xtime(x)^x.
    assign mc[4*gi]   = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
    assign mc[4*gi+1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
    assign mc[4*gi+2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
    assign mc[4*gi+3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
  end

endmodule

// File: rtl/aes_iter_encrypt.sv
// ---------------------------------------------------------------------------
// aes_iter_encrypt
// Iterative AES-128 encryption: initial AddRoundKey in the accept cycle,
// then one round per clock, result held until taken downstream.
//   clk, rst_n          clock, synchronous active-low reset
//   in_valid/in_ready   plaintext + key handshake (ready only when idle)
//   plaintext           block to encrypt
//   user_key            round key 0 (cipher key)
//   round1..round10     round keys 1..10
//   out_valid/out_ready ciphertext handshake
//   ciphertext          result (valid while out_valid)
//   busy                block in flight or waiting to be taken
// Build option: define AES_KEY_LATCH_EN to capture all round keys on accept
// so the key ports may change after the accept cycle. Without it the key
// ports must be held stable until the result is taken.
// ---------------------------------------------------------------------------
module aes_iter_encrypt
  import aes_pkg::*;
#(
  parameter int NR = NR_AES128
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] plaintext,
  input  logic [127:0] user_key,
  input  logic [127:0] round1,
  input  logic [127:0] round2,
  input  logic [127:0] round3,
  input  logic [127:0] round4,
  input  logic [127:0] round5,
  input  logic [127:0] round6,
  input  logic [127:0] round7,
  input  logic [127:0] round8,
  input  logic [127:0] round9,
  input  logic [127:0] round10,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] ciphertext,
  output logic         busy
);

  if (NR != NR_AES128) begin : g_bad_nr
    $error("aes_iter_encrypt: only NR=10 (AES-128) is supported");
  end

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_RUN  = RUN;
  localparam logic [1:0] S_DONE = DONE;

  logic [1:0] state_q, state_d;
  logic [3:0] rnd_q, rnd_d;
  aes_block_t blk_q, blk_d;
  aes_block_t round_key, round_out;
  aes_block_t key_src [1:NR_AES128];
  logic       accept;

  assign accept = in_valid && (state_q == S_IDLE);

`ifdef AES_KEY_LATCH_EN
  aes_block_t keys_q [0:NR_AES128];
  aes_block_t keys_d [0:NR_AES128];

  always_comb begin
    keys_d = keys_q;
    if (accept) begin
      keys_d = '{user_key, round1, round2, round3, round4, round5,
                 round6, round7, round8, round9, round10};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) keys_q <= '{default: '0};
    else        keys_q <= keys_d;
  end

  // Key 0 is applied straight from the port in the accept cycle, so the
  // rounds only ever read copies 1..10.
  genvar gi;
  for (gi = 1; gi <= NR_AES128; gi++) begin : g_key_src
    assign key_src[gi] = keys_q[gi];
  end
`else
  assign key_src = '{round1, round2, round3, round4, round5,
                     round6, round7, round8, round9, round10};
`endif

  always_comb begin
    round_key = key_src[1];
    for (int k = 1; k <= NR_AES128; k++) begin
      if (rnd_q == 4'(k)) round_key = key_src[k];
    end
  end

  aes_round u_round (
    .state_in    (blk_q),
    .round_key   (round_key),
    .final_round (rnd_q == 4'(NR_AES128)),
    .state_out   (round_out)
  );

  always_comb begin
    state_d = state_q;
    rnd_d   = rnd_q;
    blk_d   = blk_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          blk_d   = plaintext ^ user_key;
          rnd_d   = 4'd1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        blk_d = round_out;
        // rnd parks at 10 until the next accept reloads it.
        if (rnd_q == 4'(NR_AES128)) state_d = S_DONE;
        else                        rnd_d   = rnd_q + 4'd1;
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      rnd_q   <= 4'd0;
      blk_q   <= '0;
    end else begin
      state_q <= state_d;
      rnd_q   <= rnd_d;
      blk_q   <= blk_d;
    end
  end

  assign in_ready   = (state_q == S_IDLE);
  assign out_valid  = (state_q == S_DONE);
  assign busy       = (state_q == S_RUN) || (state_q == S_DONE);
  assign ciphertext = blk_q;

endmodule

// File: tb/tb_aes_iter_encrypt.sv
// ---------------------------------------------------------------------------
// tb_aes_iter_encrypt
// Directed bench for aes_iter_encrypt using FIPS-197 vectors. Round keys
// are expanded here from the cipher key; ciphertexts are the published
// FIPS-197 values. Honours AES_KEY_LATCH_EN for the key-port test.
// ---------------------------------------------------------------------------
module tb_aes_iter_encrypt;
  import aes_pkg::*;

  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic         busy;
  logic [127:0] plaintext = '0;
  logic [127:0] ciphertext;
  logic [127:0] kp [0:10];
  logic [127:0] rk [0:10];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  aes_iter_encrypt dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .plaintext(plaintext), .user_key(kp[0]),
    .round1(kp[1]), .round2(kp[2]), .round3(kp[3]), .round4(kp[4]),
    .round5(kp[5]), .round6(kp[6]), .round7(kp[7]), .round8(kp[8]),
    .round9(kp[9]), .round10(kp[10]),
    .out_valid(out_valid), .out_ready(out_ready),
    .ciphertext(ciphertext), .busy(busy)
  );

  function automatic void expand(input logic [127:0] key);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rcon;
    rcon = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])} ^ {rcon, 24'h0};
        rcon = xtime(rcon);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_keys(input logic [127:0] key);
    expand(key);
    for (int k = 0; k < 11; k++) kp[k] = rk[k];
  endtask

  // Present a block and hold it until the DUT takes it.
  task automatic send(input logic [127:0] pt, input logic [127:0] key, input string name);
    int n;
    load_keys(key);
    plaintext = pt;
    in_valid  = 1'b1;
    n = 0;
    while (in_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s_accept_timeout in_ready=%b required=1", name, in_ready);
    end
    tick();
    in_valid = 1'b0;
  endtask

  // Called right after the accept edge; n counts cycles from the accept cycle.
  task automatic wait_out(output int n);
    n = 1;
    while (out_valid !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    checks++;
    if ({in_ready, out_valid, busy} !== 3'b100) begin
      failures++;
      $display("FAIL reset_flags in_ready,out_valid,busy=%b required=100", {in_ready, out_valid, busy});
    end
    checks++;
    if (ciphertext !== 128'h0) begin
      failures++;
      $display("FAIL reset_ct got=%h required=0", ciphertext);
    end
    rst_n = 1'b1;
    tick();
    $display("reset: in_ready=%b out_valid=%b busy=%b", in_ready, out_valid, busy);
  endtask

  task automatic test_vector(input logic [127:0] pt, input logic [127:0] key,
                             input logic [127:0] ct, input string name, input bit check_lat);
    int n;
    out_ready = 1'b1;
    send(pt, key, name);
    checks++;
    if ({busy, in_ready} !== 2'b10) begin
      failures++;
      $display("FAIL %s_run_flags busy,in_ready=%b required=10", name, {busy, in_ready});
    end
    wait_out(n);
    if (check_lat) begin
      checks++;
      if (n != 11) begin
        failures++;
        $display("FAIL %s_latency got=%0d required=11", name, n);
      end
    end
    checks++;
    if (out_valid !== 1'b1 || ciphertext !== ct) begin
      failures++;
      $display("FAIL %s_ct out_valid=%b got=%h required=%h", name, out_valid, ciphertext, ct);
    end
    tick();
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      failures++;
      $display("FAIL %s_drain out_valid,in_ready=%b required=01", name, {out_valid, in_ready});
    end
    $display("%s: pt=%h ct=%h cycles=%0d", name, pt, ct, n);
  endtask

  task automatic test_back_to_back();
    int  n;
    bit  stable;
    logic [127:0] held;
    out_ready = 1'b0;
    send(PT_B, KEY_B, "bp");
    wait_out(n);
    held = ciphertext;
    checks++;
    if (out_valid !== 1'b1 || ciphertext !== CT_B) begin
      failures++;
      $display("FAIL bp_ct out_valid=%b got=%h required=%h", out_valid, ciphertext, CT_B);
    end
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || ciphertext !== held) stable = 1'b0;
    end
    checks++;
    if (!stable) begin
      failures++;
      $display("FAIL bp_stall_stable got=%h required=%h out_valid=%b in_ready=%b",
               ciphertext, CT_B, out_valid, in_ready);
    end
    // Second block waits on the inputs while the first is released.
    load_keys(KEY_C);
    plaintext = PT_C;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    tick();
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      failures++;
      $display("FAIL bp_release out_valid,in_ready=%b required=01", {out_valid, in_ready});
    end
    tick();
    in_valid = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL bp_second_accept busy=%b required=1", busy);
    end
    wait_out(n);
    checks++;
    if (out_valid !== 1'b1 || ciphertext !== CT_C) begin
      failures++;
      $display("FAIL bp_second_ct out_valid=%b got=%h required=%h", out_valid, ciphertext, CT_C);
    end
    tick();
    $display("back_to_back: ct1=%h ct2=%h", held, CT_C);
  endtask

  task automatic test_ignore_busy();
    int n;
    bit ready_seen;
    out_ready = 1'b1;
    send(PT_B, KEY_B, "ign");
    tick();
    plaintext  = PT_C;
    in_valid   = 1'b1;
    ready_seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (in_ready !== 1'b0) ready_seen = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    checks++;
    if (ready_seen) begin
      failures++;
      $display("FAIL ign_in_ready in_ready=1 during RUN required=0");
    end
    wait_out(n);
    checks++;
    if (out_valid !== 1'b1 || ciphertext !== CT_B) begin
      failures++;
      $display("FAIL ign_ct out_valid=%b got=%h required=%h", out_valid, ciphertext, CT_B);
    end
    tick();
    $display("ignore_busy: ct=%h", CT_B);
  endtask

  task automatic test_reset_mid();
    int n;
    out_ready = 1'b1;
    send(PT_C, KEY_C, "rst");
    for (int i = 0; i < 4; i++) tick();
    rst_n = 1'b0;
    tick();
    checks++;
    if ({in_ready, out_valid, busy} !== 3'b100 || ciphertext !== 128'h0) begin
      failures++;
      $display("FAIL rst_mid_state in_ready,out_valid,busy=%b ct=%h required=100 ct=0",
               {in_ready, out_valid, busy}, ciphertext);
    end
    rst_n = 1'b1;
    send(PT_B, KEY_B, "rst2");
    wait_out(n);
    checks++;
    if (out_valid !== 1'b1 || ciphertext !== CT_B) begin
      failures++;
      $display("FAIL rst_after_ct out_valid=%b got=%h required=%h", out_valid, ciphertext, CT_B);
    end
    tick();
    $display("reset_mid: recovered ct=%h", CT_B);
  endtask

  task automatic test_key_latch();
    int n;
    out_ready = 1'b1;
    send(PT_C, KEY_C, "klatch");
    n = 1;
    while (out_valid !== 1'b1 && n < 40) begin
`ifdef AES_KEY_LATCH_EN
      for (int k = 0; k < 11; k++) kp[k] = {$urandom, $urandom, $urandom, $urandom};
`endif
      tick();
      n++;
    end
    checks++;
    if (out_valid !== 1'b1 || ciphertext !== CT_C) begin
      failures++;
      $display("FAIL klatch_ct out_valid=%b got=%h required=%h", out_valid, ciphertext, CT_C);
    end
    tick();
    $display("key_latch: ct=%h cycles=%0d", CT_C, n);
  endtask

  initial begin
    for (int k = 0; k < 11; k++) kp[k] = '0;
    test_reset();
    test_vector(PT_B, KEY_B, CT_B, "fips_b", 1'b1);
    test_vector(PT_C, KEY_C, CT_C, "fips_c1", 1'b1);
    test_back_to_back();
    test_ignore_busy();
    test_reset_mid();
    test_key_latch();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

endmodule
